// File: rtl/forth_cpu.sv
// rtl/forth_cpu.sv - 16-bit J1-style Forth stack processor core
// TOS in a register, NOS/R from 16-deep on-chip stacks; one instruction per clock.
module forth_cpu (
   input  logic        clk,
   input  logic        reset,
   output logic [9:0]  iaddr,
   input  logic [15:0] idata,
   output logic [7:0]  daddr,
   output logic [15:0] ddata_write,
   input  logic [15:0] ddata_read,
   output logic        dwrite
);

   typedef enum logic {S_FETCH, S_EXEC} state_t;

   state_t      r_state, w_state_nxt;
   logic [9:0]  r_ip, w_ip_nxt, w_ip_inc;
   logic [15:0] r_tos, w_tos_nxt;
   logic [3:0]  r_psp, w_psp_nxt;
   logic [3:0]  r_rsp, w_rsp_nxt;
   logic [15:0] r_pstack [0:15];
   logic [15:0] r_rstack [0:15];

   logic [15:0] w_nos, w_r, w_alu;
   logic        w_pwe, w_rwe;
   logic [3:0]  w_pwa, w_rwa;
   logic [15:0] w_rwd;
   logic        w_dwrite;

   assign w_nos    = r_pstack[r_psp];
   assign w_r      = r_rstack[r_rsp];
   assign w_ip_inc = r_ip + 10'd1;

   always_comb begin
      w_alu = 16'h0000;
      case (idata[2:0])
         3'd0: w_alu = ~r_tos;
         3'd1: w_alu = {r_tos[15], r_tos[15:1]};
         3'd2: w_alu = (r_tos == 16'h0000) ? 16'hFFFF : 16'h0000;
         3'd3: w_alu = 16'h0000 - r_tos;
         3'd4: w_alu = w_nos & r_tos;
         3'd5: w_alu = w_nos | r_tos;
         3'd6: w_alu = w_nos ^ r_tos;
         3'd7: w_alu = w_nos + r_tos;
         default: w_alu = 16'h0000;
      endcase
   end

   always_comb begin
      w_state_nxt = S_EXEC;
      w_ip_nxt    = r_ip;
      w_tos_nxt   = r_tos;
      w_psp_nxt   = r_psp;
      w_rsp_nxt   = r_rsp;
      w_pwe       = 1'b0;
      w_pwa       = r_psp + 4'd1;
      w_rwe       = 1'b0;
      w_rwa       = r_rsp + 4'd1;
      w_rwd       = r_tos;
      w_dwrite    = 1'b0;

      if (r_state == S_EXEC) begin
         w_ip_nxt = w_ip_inc;
         if (!idata[15]) begin
            w_pwe     = 1'b1;
            w_psp_nxt = r_psp + 4'd1;
            w_tos_nxt = {1'b0, idata[14:0]};
         end else begin
            case (idata[14:13])
               2'b00: begin
                  w_psp_nxt = r_psp - 4'd1;
                  w_tos_nxt = w_nos;
                  if (r_tos == 16'h0000) w_ip_nxt = idata[9:0];
               end
               2'b01: w_ip_nxt = idata[9:0];
               2'b10: begin
                  w_rwe     = 1'b1;
                  w_rwd     = {6'b0, w_ip_inc};
                  w_rsp_nxt = r_rsp + 4'd1;
                  w_ip_nxt  = idata[9:0];
               end
               default: begin
                  case (idata[7:6])
                     2'b00:   w_tos_nxt = w_alu;
                     2'b01:   w_tos_nxt = r_tos;
                     2'b10:   w_tos_nxt = w_nos;
                     default: w_tos_nxt = w_r;
                  endcase
                  if (idata[9]) w_tos_nxt = ddata_read;
                  w_dwrite = idata[8];

                  case (idata[3:2])
                     2'b01: w_psp_nxt = r_psp - 4'd1;
                     2'b10: begin
                        w_pwe = 1'b1;
                        w_pwa = r_psp;
                     end
                     2'b11: begin
                        w_pwe     = 1'b1;
                        w_psp_nxt = r_psp + 4'd1;
                     end
                     default: ;
                  endcase

                  // Control flag only means return/execute for R-op 00/11.
                  if (idata[12] && idata[5:4] == 2'b00) begin
                     w_ip_nxt  = w_r[9:0];
                     w_rsp_nxt = r_rsp - 4'd1;
                  end else if (idata[12] && idata[5:4] == 2'b11) begin
                     w_rwe     = 1'b1;
                     w_rwd     = {6'b0, w_ip_inc};
                     w_rsp_nxt = r_rsp + 4'd1;
                     w_ip_nxt  = r_tos[9:0];
                  end else if (idata[5:4] == 2'b01) begin
                     w_rsp_nxt = r_rsp - 4'd1;
                  end else if (idata[5:4] == 2'b11) begin
                     w_rwe     = 1'b1;
                     w_rsp_nxt = r_rsp + 4'd1;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
         r_ip    <= 10'd0;
         r_tos   <= 16'h0000;
         r_psp   <= 4'd0;
         r_rsp   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_ip    <= w_ip_nxt;
         r_tos   <= w_tos_nxt;
         r_psp   <= w_psp_nxt;
         r_rsp   <= w_rsp_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_pwe) r_pstack[w_pwa] <= r_tos;
      if (w_rwe) r_rstack[w_rwa] <= w_rwd;
   end

   // Next IP goes straight out so synchronous instruction RAM never bubbles.
   assign iaddr       = w_ip_nxt;
   assign daddr       = r_tos[7:0];
   assign dwrite      = w_dwrite;
   assign ddata_write = w_dwrite ? w_nos : 16'h0000;

endmodule

// File: tb/tb_forth_cpu.sv
// tb/tb_forth_cpu.sv - directed self-checking bench for forth_cpu
module tb_forth_cpu;

   logic        clk;
   logic        reset;
   logic [9:0]  iaddr;
   logic [15:0] idata;
   logic [7:0]  daddr;
   logic [15:0] ddata_write;
   logic [15:0] ddata_read;
   logic        dwrite;

   logic [15:0] imem [0:1023];
   logic [15:0] dmem [0:255];

   int n_checks;
   int n_fail;

   forth_cpu dut (
      .clk         (clk),
      .reset       (reset),
      .iaddr       (iaddr),
      .idata       (idata),
      .daddr       (daddr),
      .ddata_write (ddata_write),
      .ddata_read  (ddata_read),
      .dwrite      (dwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ddata_read = dmem[daddr];

   always @(posedge clk) begin
      idata <= imem[iaddr];
      if (dwrite) dmem[daddr] <= ddata_write;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) imem[i] = 16'hE040;
      for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
   endtask

   task automatic boot();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [15:0] ip16();
      return {6'b0, dut.r_ip};
   endfunction

   function automatic logic [15:0] nos();
      return dut.r_pstack[dut.r_psp];
   endfunction

   function automatic logic [15:0] rtop();
      return dut.r_rstack[dut.r_rsp];
   endfunction

   task automatic alu2(input logic [15:0] a, input logic [15:0] b, input logic [15:0] op,
                       input logic [15:0] exp, input string tag);
      clear_mem();
      imem[0] = a; imem[1] = b; imem[2] = op;
      boot();
      run(3);
      chk(tag, dut.r_tos, exp);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      idata    = 16'h0000;
      reset    = 1'b1;
      clear_mem();
      #1 reset = 1'b0;
      run(3);
      chk("rst_iaddr", {6'b0, iaddr}, 16'h0000);
      chk("rst_daddr", {8'b0, daddr}, 16'h0000);
      chk("rst_dwrite", {15'b0, dwrite}, 16'h0000);
      chk("rst_dwdata", ddata_write, 16'h0000);
      chk("rst_ip", ip16(), 16'h0000);
      chk("rst_tos", dut.r_tos, 16'h0000);
      chk("rst_psp", {12'b0, dut.r_psp}, 16'h0000);
      chk("rst_rsp", {12'b0, dut.r_rsp}, 16'h0000);

      // literal at IP 100
      clear_mem();
      imem[0] = 16'hA100; imem[16'h100] = 16'h0000;
      boot();
      chk("fetch_ip", ip16(), 16'h0000);
      run(2);
      chk("lit0_ip", ip16(), 16'h0101);
      chk("lit0_psp", {12'b0, dut.r_psp}, 16'h0001);
      chk("lit0_tos", dut.r_tos, 16'h0000);

      clear_mem();
      imem[0] = 16'h1000; imem[1] = 16'h2000;
      boot();
      run(2);
      chk("lit2_ip", ip16(), 16'h0002);
      chk("lit2_psp", {12'b0, dut.r_psp}, 16'h0002);
      chk("lit2_tos", dut.r_tos, 16'h2000);
      chk("lit2_ps2", dut.r_pstack[2], 16'h1000);

      // unary ALU
      clear_mem();
      imem[0] = 16'h7FFF; imem[1] = 16'hE000; imem[2] = 16'hE001;
      boot();
      run(2);
      chk("not", dut.r_tos, 16'h8000);
      run(1);
      chk("not_sra", dut.r_tos, 16'hC000);
      clear_mem();
      imem[0] = 16'h7FFF; imem[1] = 16'hE001;
      boot();
      run(2);
      chk("sra", dut.r_tos, 16'h3FFF);
      clear_mem();
      imem[0] = 16'h0000; imem[1] = 16'hE002; imem[2] = 16'h1000; imem[3] = 16'hE002;
      imem[4] = 16'h0001; imem[5] = 16'hE003;
      boot();
      run(2);
      chk("zeq_0", dut.r_tos, 16'hFFFF);
      run(2);
      chk("zeq_1000", dut.r_tos, 16'h0000);
      run(2);
      chk("neg", dut.r_tos, 16'hFFFF);

      // binary ALU
      alu2(16'h1234, 16'h5678, 16'hE004, 16'h1230, "and");
      chk("and_psp", {12'b0, dut.r_psp}, 16'h0001);
      alu2(16'h1234, 16'h5678, 16'hE005, 16'h567C, "or");
      alu2(16'h1234, 16'h5678, 16'hE006, 16'h444C, "xor");
      alu2(16'h1234, 16'h5678, 16'hE007, 16'h68AC, "add");
      chk("add_psp", {12'b0, dut.r_psp}, 16'h0001);

      // stack ops
      alu2(16'h1234, 16'h5678, 16'hE088, 16'h1234, "swap_tos");
      chk("swap_nos", nos(), 16'h5678);
      clear_mem();
      imem[0] = 16'h1234; imem[1] = 16'h5678; imem[2] = 16'h0ABC;
      imem[3] = 16'hE0B4; imem[4] = 16'hE084; imem[5] = 16'hE0DC;
      boot();
      run(4);
      chk("tor_psp", {12'b0, dut.r_psp}, 16'h0002);
      chk("tor_rsp", {12'b0, dut.r_rsp}, 16'h0001);
      chk("tor_tos", dut.r_tos, 16'h5678);
      chk("tor_r", rtop(), 16'h0ABC);
      run(2);
      chk("rfrom_ip", ip16(), 16'h0006);
      chk("rfrom_psp", {12'b0, dut.r_psp}, 16'h0002);
      chk("rfrom_rsp", {12'b0, dut.r_rsp}, 16'h0000);
      chk("rfrom_tos", dut.r_tos, 16'h0ABC);
      chk("rfrom_nos", nos(), 16'h1234);

      // branches
      clear_mem();
      imem[0] = 16'hA300;
      boot();
      chk("br_iaddr", {6'b0, iaddr}, 16'h0300);
      run(1);
      chk("br_ip", ip16(), 16'h0300);
      clear_mem();
      imem[0] = 16'h0000; imem[1] = 16'h8300;
      boot();
      run(2);
      chk("zbr_taken_ip", ip16(), 16'h0300);
      chk("zbr_taken_psp", {12'b0, dut.r_psp}, 16'h0000);
      clear_mem();
      imem[0] = 16'h0001; imem[1] = 16'h8300;
      boot();
      run(2);
      chk("zbr_fall_ip", ip16(), 16'h0002);
      chk("zbr_fall_psp", {12'b0, dut.r_psp}, 16'h0000);

      // calls, execute, return
      clear_mem();
      imem[0] = 16'hC300;
      boot();
      run(1);
      chk("call_ip", ip16(), 16'h0300);
      chk("call_rsp", {12'b0, dut.r_rsp}, 16'h0001);
      chk("call_r", rtop(), 16'h0001);
      clear_mem();
      imem[0] = 16'h0300; imem[1] = 16'hF074;
      boot();
      run(2);
      chk("exe_ip", ip16(), 16'h0300);
      chk("exe_psp", {12'b0, dut.r_psp}, 16'h0000);
      chk("exe_rsp", {12'b0, dut.r_rsp}, 16'h0001);
      chk("exe_r", rtop(), 16'h0002);
      clear_mem();
      imem[0] = 16'h0300; imem[1] = 16'hE0B4; imem[2] = 16'h1234; imem[3] = 16'hF000;
      boot();
      run(4);
      chk("ret_ip", ip16(), 16'h0300);
      chk("ret_rsp", {12'b0, dut.r_rsp}, 16'h0000);
      chk("ret_psp", {12'b0, dut.r_psp}, 16'h0001);
      chk("ret_tos", dut.r_tos, 16'hEDCB);

      // store then load through data port
      clear_mem();
      imem[0] = 16'h4321; imem[1] = 16'h0010; imem[2] = 16'hE184;
      imem[3] = 16'h0010; imem[4] = 16'hE200;
      boot();
      run(1);
      chk("nost_dwrite", {15'b0, dwrite}, 16'h0000);
      chk("nost_wdata", ddata_write, 16'h0000);
      run(1);
      chk("st_dwrite", {15'b0, dwrite}, 16'h0001);
      chk("st_wdata", ddata_write, 16'h4321);
      chk("st_daddr", {8'b0, daddr}, 16'h0010);
      run(1);
      chk("st_mem", dmem[8'h10], 16'h4321);
      chk("st_psp", {12'b0, dut.r_psp}, 16'h0001);
      run(2);
      chk("ld_tos", dut.r_tos, 16'h4321);

      // pointer wrap on underflow
      clear_mem();
      imem[0] = 16'hE084;
      boot();
      run(1);
      chk("wrap_psp", {12'b0, dut.r_psp}, 16'h000F);

      // asynchronous reset mid-run
      clear_mem();
      imem[0] = 16'h1234; imem[1] = 16'h5678; imem[2] = 16'hE007;
      boot();
      run(2);
      #2 reset = 1'b0;
      #1;
      chk("mid_ip", ip16(), 16'h0000);
      chk("mid_iaddr", {6'b0, iaddr}, 16'h0000);
      chk("mid_tos", dut.r_tos, 16'h0000);
      chk("mid_psp", {12'b0, dut.r_psp}, 16'h0000);
      chk("mid_dwrite", {15'b0, dwrite}, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_fetch_ip", ip16(), 16'h0000);
      chk("mid_fetch_tos", dut.r_tos, 16'h0000);
      run(1);
      chk("mid_resume_ip", ip16(), 16'h0001);
      chk("mid_resume_tos", dut.r_tos, 16'h1234);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
